// File: rtl/ahb_reg_slave_pkg.sv
// Shared AHB-lite types and helpers for the register slave.
package ahb_reg_slave_pkg;

    localparam int AHB_WORD_W = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1,
        HRESP_RETRY = 2'd2,
        HRESP_SPLIT = 2'd3
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slv_state_e;

    // NONSEQ and SEQ carry a transfer; IDLE and BUSY do not.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_reg_slave_bank.sv
// Register storage: constant ID word, live status word, and RW config words
// with a single write port and write-to-read forwarding.
module ahb_reg_slave_bank
    import ahb_reg_slave_pkg::*;
#(
    parameter int                    NUM_REGS = 8,
    parameter logic [AHB_WORD_W-1:0] ID_VALUE = 32'hA4B5_0001,
    localparam int                   IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                             hclk,
    input  logic                             hrst,
    input  logic                             wr_en,
    input  logic [IDX_W-1:0]                 wr_idx,
    input  logic [AHB_WORD_W-1:0]            wr_data,
    input  logic [IDX_W-1:0]                 rd_idx,
    input  logic [AHB_WORD_W-1:0]            status_i,
    output logic [AHB_WORD_W-1:0]            rd_data,
    output logic [(NUM_REGS-2)*AHB_WORD_W-1:0] cfg_o
);

    logic [AHB_WORD_W-1:0] cfg_q [NUM_REGS-2];

    // Config word storage; regs 0 and 1 never reach the write port because
    // the decoder flags writes to them as errors.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            for (int i = 0; i < NUM_REGS-2; i++) cfg_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS-2; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i + 2))) cfg_q[i] <= wr_data;
            end
        end
    end

    // Read mux; a write committing on this edge to the same word wins so a
    // back-to-back read sees the new value.
    always_comb begin
        rd_data = '0;
        if (wr_en && (wr_idx == rd_idx)) begin
            rd_data = wr_data;
        end else if (rd_idx == IDX_W'(0)) begin
            rd_data = ID_VALUE;
        end else if (rd_idx == IDX_W'(1)) begin
            rd_data = status_i;
        end else begin
            for (int i = 0; i < NUM_REGS-2; i++) begin
                if (rd_idx == IDX_W'(i + 2)) rd_data = cfg_q[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS-2; g++) begin : g_cfg
        assign cfg_o[g*AHB_WORD_W +: AHB_WORD_W] = cfg_q[g];
    end

endmodule

// File: rtl/ahb_reg_slave.sv
// AHB-lite register slave: address decode, wait-state insertion and the
// two-cycle ERROR response around the register bank.
//
//  state | meaning
//  IDLE  | no transfer in data phase, hready=1 OKAY
//  WAIT  | OKAY transfer stalling, hready=0, cnt counts down to 0
//  DATA  | OKAY data phase completing, write commits on exit, read data valid
//  ERR1  | first ERROR cycle, hready=0 hresp=ERROR
//  ERR2  | second ERROR cycle, hready=1 hresp=ERROR, may accept next transfer
module ahb_reg_slave
    import ahb_reg_slave_pkg::*;
#(
    parameter logic [AHB_WORD_W-1:0] BASE_ADDR   = 32'h4000_0000,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_STATES = 0,
    parameter logic [AHB_WORD_W-1:0] ID_VALUE    = 32'hA4B5_0001
) (
    input  logic                               hclk,
    input  logic                               hrst,
    input  logic                               hsel,
    input  logic [AHB_WORD_W-1:0]              haddr,
    input  logic [1:0]                         htrans,
    input  logic                               hwrite,
    input  logic [3:0]                         hprot,
    input  logic [AHB_WORD_W-1:0]              hwdata,
    output logic [AHB_WORD_W-1:0]              hrdata,
    output logic                               hready,
    output logic [1:0]                         hresp,
    input  logic [AHB_WORD_W-1:0]              status_i,
    output logic [(NUM_REGS-2)*AHB_WORD_W-1:0] cfg_o
);

    localparam int                    IDX_W     = $clog2(NUM_REGS);
    localparam logic [AHB_WORD_W-1:0] WIN_BYTES = AHB_WORD_W'(NUM_REGS * 4);

    slv_state_e            state_q;
    hresp_e                hresp_q;
    logic [3:0]            cnt_q;
    logic [IDX_W-1:0]      d_idx_q;
    logic                  d_write_q;

    logic                  accept;
    logic                  a_err;
    logic [AHB_WORD_W-1:0] a_off;
    logic [IDX_W-1:0]      a_idx;
    logic                  wr_en;
    logic [IDX_W-1:0]      rd_idx;
    logic [AHB_WORD_W-1:0] rd_data;
    logic                  unused_inputs;

    // Protection attributes carry no meaning for this slave.
    assign unused_inputs = ^hprot;

    assign accept = hsel && htrans_active(htrans) && hready;
    assign a_off  = haddr - BASE_ADDR;
    assign a_idx  = a_off[IDX_W+1:2];
    assign a_err  = (haddr < BASE_ADDR) || (a_off >= WIN_BYTES) ||
                    (haddr[1:0] != 2'b00) || (hwrite && (a_idx < IDX_W'(2)));

    // The write data arrives in the data phase, so commit on the edge that
    // leaves DATA; the bank drops it if hrst is high on that edge.
    assign wr_en  = (state_q == ST_DATA) && d_write_q;

    // Reads load on the edge entering DATA: from WAIT that is the latched
    // index, otherwise the transfer being accepted right now.
    assign rd_idx = (state_q == ST_WAIT) ? d_idx_q : a_idx;

    assign hresp  = hresp_q;

    ahb_reg_slave_bank #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .hclk     (hclk),
        .hrst     (hrst),
        .wr_en    (wr_en),
        .wr_idx   (d_idx_q),
        .wr_data  (hwdata),
        .rd_idx   (rd_idx),
        .status_i (status_i),
        .rd_data  (rd_data),
        .cfg_o    (cfg_o)
    );

    // Transfer FSM with registered hready/hresp/hrdata.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            state_q   <= ST_IDLE;
            hready    <= 1'b1;
            hresp_q   <= HRESP_OKAY;
            hrdata    <= '0;
            cnt_q     <= '0;
            d_idx_q   <= '0;
            d_write_q <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_DATA;
                        hready  <= 1'b1;
                        hrdata  <= d_write_q ? '0 : rd_data;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state_q <= ST_ERR2;
                    hready  <= 1'b1;
                    hresp_q <= HRESP_ERROR;
                    hrdata  <= '0;
                end
                default: begin
                    if (accept) begin
                        d_idx_q   <= a_idx;
                        d_write_q <= hwrite;
                        if (a_err) begin
                            state_q <= ST_ERR1;
                            hready  <= 1'b0;
                            hresp_q <= HRESP_ERROR;
                            hrdata  <= '0;
                        end else if (WAIT_STATES > 0) begin
                            state_q <= ST_WAIT;
                            hready  <= 1'b0;
                            hresp_q <= HRESP_OKAY;
                            cnt_q   <= 4'(WAIT_STATES - 1);
                            hrdata  <= '0;
                        end else begin
                            state_q <= ST_DATA;
                            hready  <= 1'b1;
                            hresp_q <= HRESP_OKAY;
                            hrdata  <= hwrite ? '0 : rd_data;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        hready  <= 1'b1;
                        hresp_q <= HRESP_OKAY;
                        hrdata  <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_reg_slave.sv
// Directed bench: one slave with no wait states, one with three, sharing the bus.
module tb_ahb_reg_slave;

    logic         hclk = 1'b0;
    logic         hrst;
    logic         hsel0, hsel3;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic         hwrite;
    logic [3:0]   hprot;
    logic [31:0]  hwdata;
    logic [31:0]  status_i;
    logic [31:0]  hrdata0, hrdata3;
    logic         hready0, hready3;
    logic [1:0]   hresp0, hresp3;
    logic [191:0] cfg0, cfg3;

    int total = 0;
    int bad   = 0;

    int          nw;
    logic [1:0]  rf, rl;
    logic [31:0] rd;

    always #5 hclk = ~hclk;

    ahb_reg_slave #(.WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hrst(hrst), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata0),
        .hready(hready0), .hresp(hresp0), .status_i(status_i), .cfg_o(cfg0)
    );

    ahb_reg_slave #(.WAIT_STATES(3)) dut3 (
        .hclk(hclk), .hrst(hrst), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata3),
        .hready(hready3), .hresp(hresp3), .status_i(status_i), .cfg_o(cfg3)
    );

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One non-pipelined transfer; reports hready-low cycles, first and final hresp, read data.
    task automatic xfer(input bit s3, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int nwait, output logic [1:0] r_first, output logic [1:0] r_last,
                        output logic [31:0] rdata);
        @(negedge hclk);
        hsel0  = !s3;
        hsel3  = s3;
        htrans = 2'b10;
        haddr  = a;
        hwrite = w;
        @(posedge hclk);
        @(negedge hclk);
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hwdata = d;
        nwait  = 0;
        r_first = s3 ? hresp3 : hresp0;
        while (!(s3 ? hready3 : hready0) && nwait < 20) begin
            nwait++;
            @(negedge hclk);
        end
        r_last = s3 ? hresp3 : hresp0;
        rdata  = s3 ? hrdata3 : hrdata0;
        @(posedge hclk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hrst = 1'b1; hsel0 = 1'b0; hsel3 = 1'b0; haddr = '0; htrans = 2'b00;
        hwrite = 1'b0; hprot = 4'h3; hwdata = '0; status_i = '0;

        // T1 reset
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        hrst = 1'b0;
        chk("rst_hready0", 192'(hready0), 192'(1));
        chk("rst_hresp0",  192'(hresp0),  192'(0));
        chk("rst_hrdata0", 192'(hrdata0), 192'(0));
        chk("rst_cfg0",    cfg0,          192'(0));
        chk("rst_hready3", 192'(hready3), 192'(1));
        chk("rst_cfg3",    cfg3,          192'(0));

        // T2 write/read, no wait states
        xfer(0, 1'b1, 32'h4000_0008, 32'hDEAD_BEEF, nw, rf, rl, rd);
        chk("wr08_nwait", 192'(nw), 192'(0));
        chk("wr08_resp",  192'(rl), 192'(0));
        @(negedge hclk);
        chk("wr08_cfg",   cfg0, 192'h0000_0000_DEAD_BEEF);
        xfer(0, 1'b0, 32'h4000_0008, 32'h0, nw, rf, rl, rd);
        chk("rd08_nwait", 192'(nw), 192'(0));
        chk("rd08_data",  192'(rd), 192'(32'hDEAD_BEEF));
        @(negedge hclk);
        chk("idle_hrdata", 192'(hrdata0), 192'(0));

        // T3 ID and status
        xfer(0, 1'b0, 32'h4000_0000, 32'h0, nw, rf, rl, rd);
        chk("rd_id", 192'(rd), 192'(32'hA4B5_0001));
        status_i = 32'h1234_5678;
        xfer(0, 1'b0, 32'h4000_0004, 32'h0, nw, rf, rl, rd);
        chk("rd_status", 192'(rd), 192'(32'h1234_5678));

        // T4 errors
        xfer(0, 1'b1, 32'h4000_0000, 32'hFFFF_FFFF, nw, rf, rl, rd);
        chk("err_wr0_nwait", 192'(nw), 192'(1));
        chk("err_wr0_r1",    192'(rf), 192'(1));
        chk("err_wr0_r2",    192'(rl), 192'(1));
        @(negedge hclk);
        chk("err_wr0_cfg",   cfg0, 192'h0000_0000_DEAD_BEEF);
        xfer(0, 1'b1, 32'h4000_0004, 32'hFFFF_FFFF, nw, rf, rl, rd);
        chk("err_wr1_r2",    192'(rl), 192'(1));
        xfer(0, 1'b0, 32'h4000_0020, 32'h0, nw, rf, rl, rd);
        chk("err_rd20_nwait", 192'(nw), 192'(1));
        chk("err_rd20_r1",    192'(rf), 192'(1));
        chk("err_rd20_r2",    192'(rl), 192'(1));
        chk("err_rd20_data",  192'(rd), 192'(0));
        xfer(0, 1'b0, 32'h4000_0009, 32'h0, nw, rf, rl, rd);
        chk("err_rd09_nwait", 192'(nw), 192'(1));
        chk("err_rd09_r2",    192'(rl), 192'(1));
        xfer(0, 1'b0, 32'h3FFF_FFFC, 32'h0, nw, rf, rl, rd);
        chk("err_below_r2",   192'(rl), 192'(1));
        xfer(0, 1'b0, 32'h4000_001C, 32'h0, nw, rf, rl, rd);
        chk("rd_last_resp",   192'(rl), 192'(0));
        chk("rd_last_nwait",  192'(nw), 192'(0));
        @(negedge hclk);
        chk("err_cfg_keep",   cfg0, 192'h0000_0000_DEAD_BEEF);

        // T5 three wait states
        xfer(1, 1'b1, 32'h4000_000C, 32'h0000_0005, nw, rf, rl, rd);
        chk("ws3_wr_nwait", 192'(nw), 192'(3));
        chk("ws3_wr_r1",    192'(rf), 192'(0));
        chk("ws3_wr_resp",  192'(rl), 192'(0));
        @(negedge hclk);
        chk("ws3_wr_cfg",   cfg3, 192'h0000_0005_0000_0000);
        xfer(1, 1'b0, 32'h4000_000C, 32'h0, nw, rf, rl, rd);
        chk("ws3_rd_nwait", 192'(nw), 192'(3));
        chk("ws3_rd_data",  192'(rd), 192'(5));
        xfer(1, 1'b0, 32'h4000_0009, 32'h0, nw, rf, rl, rd);
        chk("ws3_err_nwait", 192'(nw), 192'(1));
        chk("ws3_err_r2",    192'(rl), 192'(1));

        // T6 pipelined write then read of the same word
        @(negedge hclk);
        hsel0 = 1'b1; htrans = 2'b10; haddr = 32'h4000_0010; hwrite = 1'b1;
        @(posedge hclk);
        @(negedge hclk);
        chk("pipe_wr_ready", 192'(hready0), 192'(1));
        hwdata = 32'h0000_00AA; hwrite = 1'b0;
        @(posedge hclk);
        @(negedge hclk);
        hsel0 = 1'b0; htrans = 2'b00;
        chk("pipe_rd_ready", 192'(hready0), 192'(1));
        chk("pipe_rd_fwd",   192'(hrdata0), 192'(32'h0000_00AA));
        chk("pipe_cfg",      cfg0, {96'h0, 32'h0000_00AA, 32'h0, 32'hDEAD_BEEF});
        @(posedge hclk);

        // Reset while a write sits in WAIT
        @(negedge hclk);
        hsel3 = 1'b1; htrans = 2'b10; haddr = 32'h4000_0014; hwrite = 1'b1;
        @(posedge hclk);
        @(negedge hclk);
        hsel3 = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h0000_0077;
        chk("rstw_in_wait", 192'(hready3), 192'(0));
        hrst = 1'b1;
        @(posedge hclk);
        @(negedge hclk);
        hrst = 1'b0;
        chk("rstw_hready", 192'(hready3), 192'(1));
        chk("rstw_hresp",  192'(hresp3),  192'(0));
        chk("rstw_cfg",    cfg3,          192'(0));
        repeat (5) @(negedge hclk);
        chk("rstw_cfg_late",  cfg3,          192'(0));
        chk("rstw_hready_late", 192'(hready3), 192'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
